// File: rtl/mem_lsu_fsm.sv
// mem_lsu_fsm: MEM-stage load/store engine acting as a req/ack data-bus master.
// Steers big-endian byte lanes, extends loads, tracks the LL/SC reservation,
// stalls the pipeline while busy and raises AdEL/AdES/DBE exceptions.
// Build option: define LSU_ALIGN_EXC_EN to trap misaligned half/word accesses;
// without it the low address bits below the access size are cleared instead.
module mem_lsu_fsm #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [3:0]          op_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                flush_i,
    output logic                stall_req_o,
    output logic                done_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                exc_o,
    output logic [4:0]          exc_code_o,
    output logic [ADDR_W-1:0]   bad_vaddr_o,
    output logic                llbit_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic                bus_ack_i,
    input  logic [DATA_W-1:0]   bus_rdata_i
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;
    localparam logic [3:0] OP_LL  = 4'd8;
    localparam logic [3:0] OP_SC  = 4'd9;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {S_IDLE, S_CHK, S_BUS, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_llbit;
    logic [CNT_W-1:0]    r_tcnt;
    logic                r_flushed;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [LANES-1:0]    r_bus_sel;
    logic [DATA_W-1:0]   r_bus_wdata;

    logic [2:0]          w_nbytes;
    logic                w_store;
    logic                w_signed;
    logic [OFF_W-1:0]    w_raw_off;
    logic [OFF_W-1:0]    w_off;
    logic                w_fault;
    logic [LANES-1:0]    w_sel;
    logic [DATA_W-1:0]   w_wrep;
    int unsigned         w_rsh;
    logic [31:0]         w_sh32;
    logic [DATA_W-1:0]   w_ext;
    logic                w_tmo;
    logic                w_quiet;
    logic                w_op_valid;
    logic                w_stall;
    logic                w_done;
    logic                w_exc;
    logic [4:0]          w_code;
    logic                w_bus_req;
    logic                w_latch;
    logic                w_go_bus;
    logic                w_sc_fail;
    logic                w_ack_ok;

    assign w_op_valid = (op_i <= OP_SC);
    assign w_raw_off  = r_addr[OFF_W-1:0];
    assign w_off      = w_raw_off & ~OFF_W'(w_nbytes - 3'd1);
    assign w_tmo      = (TIMEOUT_CYC != 0) && (r_tcnt == CNT_W'(TIMEOUT_CYC));
    // A flush seen at any point during the bus wait silences the completion.
    assign w_quiet    = r_flushed || flush_i;

`ifdef LSU_ALIGN_EXC_EN
    logic w_misalign;
    assign w_misalign = (w_raw_off & OFF_W'(w_nbytes - 3'd1)) != '0;
    assign w_fault    = w_misalign;
`else
    assign w_fault    = 1'b0;
`endif

    // Decode the latched opcode into access size, direction and signedness
    always_comb begin
        w_nbytes = 3'd4;
        w_store  = 1'b0;
        w_signed = 1'b0;
        case (r_op)
            OP_LB:   begin w_nbytes = 3'd1; w_signed = 1'b1; end
            OP_LBU:  begin w_nbytes = 3'd1; end
            OP_LH:   begin w_nbytes = 3'd2; w_signed = 1'b1; end
            OP_LHU:  begin w_nbytes = 3'd2; end
            OP_LW:   begin w_nbytes = 3'd4; w_signed = 1'b1; end
            OP_SB:   begin w_nbytes = 3'd1; w_store  = 1'b1; end
            OP_SH:   begin w_nbytes = 3'd2; w_store  = 1'b1; end
            OP_SW:   begin w_nbytes = 3'd4; w_store  = 1'b1; end
            OP_LL:   begin w_nbytes = 3'd4; w_signed = 1'b1; end
            OP_SC:   begin w_nbytes = 3'd4; w_store  = 1'b1; end
            default: ;
        endcase
    end

    // Byte enables (MSB lane = lowest address) and store data replicated per lane
    always_comb begin
        w_sel  = '0;
        w_wrep = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (i >= 32'(w_off) && i < 32'(w_off) + 32'(w_nbytes))
                w_sel[LANES-1-i] = 1'b1;
            case (w_nbytes)
                3'd1:    w_wrep[8*i +: 8] = r_wdata[7:0];
                3'd2:    w_wrep[8*i +: 8] = r_wdata[8*(i%2) +: 8];
                default: w_wrep[8*i +: 8] = r_wdata[8*(i%4) +: 8];
            endcase
        end
    end

    // Right-align the addressed bytes of the read data and extend to full width
    always_comb begin
        w_rsh  = 8 * (32'(LANES) - 32'(w_off) - 32'(w_nbytes));
        w_sh32 = 32'(bus_rdata_i >> w_rsh);
        case (w_nbytes)
            3'd1:    w_ext = w_signed ? DATA_W'($signed(w_sh32[7:0]))  : DATA_W'(w_sh32[7:0]);
            3'd2:    w_ext = w_signed ? DATA_W'($signed(w_sh32[15:0])) : DATA_W'(w_sh32[15:0]);
            default: w_ext = w_signed ? DATA_W'($signed(w_sh32))       : DATA_W'(w_sh32);
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state and per-state control outputs
    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_done    = 1'b0;
        w_exc     = 1'b0;
        w_code    = '0;
        w_bus_req = 1'b0;
        w_latch   = 1'b0;
        w_go_bus  = 1'b0;
        w_sc_fail = 1'b0;
        w_ack_ok  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i && !flush_i && w_op_valid) begin
                    w_latch = 1'b1;
                    w_next  = S_CHK;
                end
            end
            S_CHK: begin
                w_stall = 1'b1;
                if (flush_i) begin
                    w_next = S_IDLE;
                end else if (w_fault) begin
                    w_exc  = 1'b1;
                    w_code = w_store ? EXC_ADES : EXC_ADEL;
                    w_next = S_IDLE;
                end else if (r_op == OP_SC && !r_llbit) begin
                    w_sc_fail = 1'b1;
                    w_next    = S_DONE;
                end else begin
                    w_go_bus = 1'b1;
                    w_next   = S_BUS;
                end
            end
            S_BUS: begin
                w_stall = 1'b1;
                if (w_tmo) begin
                    w_exc  = !w_quiet;
                    w_code = w_quiet ? 5'd0 : EXC_DBE;
                    w_next = S_IDLE;
                end else begin
                    w_bus_req = 1'b1;
                    if (bus_ack_i) begin
                        w_ack_ok = 1'b1;
                        w_next   = w_quiet ? S_IDLE : S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_done = !flush_i;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, bus drive registers, timeout counter and load result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_tcnt      <= '0;
            r_flushed   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_sel   <= '0;
            r_bus_wdata <= '0;
        end else begin
            if (w_latch) begin
                r_op    <= op_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
            end
            if (w_go_bus) begin
                r_bus_we    <= w_store;
                r_bus_addr  <= {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                r_bus_sel   <= w_sel;
                r_bus_wdata <= w_wrep;
                r_tcnt      <= '0;
                r_flushed   <= 1'b0;
            end else if (r_state == S_BUS) begin
                if (r_tcnt != '1) r_tcnt <= r_tcnt + 1'b1;
                if (flush_i)      r_flushed <= 1'b1;
            end
            if (w_sc_fail) r_rdata <= '0;
            if (w_ack_ok && !w_quiet) begin
                if (r_op == OP_SC)  r_rdata <= DATA_W'(1'b1);
                else if (!w_store)  r_rdata <= w_ext;
            end
        end
    end

    // LL/SC reservation bit; any flush drops it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_llbit <= 1'b0;
        end else if (flush_i) begin
            r_llbit <= 1'b0;
        end else if (w_ack_ok && !r_flushed) begin
            if (r_op == OP_LL)      r_llbit <= 1'b1;
            else if (r_op == OP_SC) r_llbit <= 1'b0;
        end
    end

    assign stall_req_o = w_stall;
    assign done_o      = w_done;
    assign rdata_o     = r_rdata;
    assign exc_o       = w_exc;
    assign exc_code_o  = w_code;
    assign bad_vaddr_o = w_exc ? r_addr : '0;
    assign llbit_o     = r_llbit;
    assign bus_req_o   = w_bus_req;
    assign bus_we_o    = r_bus_we;
    assign bus_addr_o  = r_bus_addr;
    assign bus_sel_o   = r_bus_sel;
    assign bus_wdata_o = r_bus_wdata;

endmodule
